// File: rtl/wishbone_peripheral_bridge_pkg.sv
// Shared definitions for the Wishbone-to-peripheral-bus bridge: FSM states and bus constants.
package wishbone_peripheral_bridge_pkg;

  localparam int unsigned PBUS_ADDR_W        = 24;
  localparam logic [31:0] PBUS_UNMAPPED_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/wishbone_peripheral_bridge.sv
// Wishbone classic slave mastering the shared peripheral bus; one access in flight.
// Optional busy timeout with wb_err_o is enabled by defining BRIDGE_TIMEOUT_EN.
module wishbone_peripheral_bridge
  import wishbone_peripheral_bridge_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDRESS   = 8'h30,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_data_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [31:0]            wb_data_o,
  output logic                   peripheralBus_we,
  output logic                   peripheralBus_oe,
  input  logic                   peripheralBus_busy,
  output logic [PBUS_ADDR_W-1:0] peripheralBus_address,
  output logic [3:0]             peripheralBus_byteSelect,
  output logic [31:0]            peripheralBus_dataWrite,
  input  logic [31:0]            peripheralBus_dataRead,
  input  logic                   requestOutput
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  bridge_state_t state;
  logic          is_write;
  logic          select;

  assign select = wb_cyc_i & wb_stb_i & (wb_adr_i[31:24] == BASE_ADDRESS);

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] busy_count;
  logic       err_q;
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                    <= ST_IDLE;
      is_write                 <= 1'b0;
      wb_ack_o                 <= 1'b0;
      wb_data_o                <= '0;
      peripheralBus_we         <= 1'b0;
      peripheralBus_oe         <= 1'b0;
      peripheralBus_address    <= '0;
      peripheralBus_byteSelect <= '0;
      peripheralBus_dataWrite  <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      busy_count               <= '0;
      err_q                    <= 1'b0;
`endif
    end else begin
      wb_ack_o <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (select) begin
            peripheralBus_address    <= wb_adr_i[PBUS_ADDR_W-1:0];
            peripheralBus_byteSelect <= wb_sel_i;
            peripheralBus_dataWrite  <= wb_data_i;
            is_write                 <= wb_we_i;
            peripheralBus_we         <= wb_we_i;
            peripheralBus_oe         <= ~wb_we_i;
`ifdef BRIDGE_TIMEOUT_EN
            busy_count               <= '0;
`endif
            state                    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // An abandoned cycle takes priority over completion so no ack is emitted.
          if (!wb_cyc_i) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            state            <= ST_IDLE;
          end else if (!peripheralBus_busy) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            wb_ack_o         <= 1'b1;
            if (is_write)           wb_data_o <= '0;
            else if (requestOutput) wb_data_o <= peripheralBus_dataRead;
            else                    wb_data_o <= PBUS_UNMAPPED_DATA;
            state            <= ST_RESPOND;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (busy_count == TIMEOUT_LAST) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            err_q            <= 1'b1;
            wb_data_o        <= PBUS_UNMAPPED_DATA;
            state            <= ST_RESPOND;
          end else begin
            busy_count <= busy_count + 8'd1;
          end
`endif
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_peripheral_bridge.sv
// Directed, table-driven bench for wishbone_peripheral_bridge plus multi-cycle corner sequences.
module tb_wishbone_peripheral_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we_in = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, err;
  logic [31:0] rd_out;
  logic        p_we, p_oe;
  logic        busy = 1'b0;
  logic [23:0] p_addr;
  logic [3:0]  p_sel;
  logic [31:0] p_wd;
  logic [31:0] rdat = '0;
  logic        req = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_no++;

  wishbone_peripheral_bridge #(
    .BASE_ADDRESS  (8'h30),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .wb_cyc_i                (cyc),
    .wb_stb_i                (stb),
    .wb_we_i                 (we_in),
    .wb_sel_i                (sel),
    .wb_adr_i                (adr),
    .wb_data_i               (wdat),
    .wb_ack_o                (ack),
    .wb_err_o                (err),
    .wb_data_o               (rd_out),
    .peripheralBus_we        (p_we),
    .peripheralBus_oe        (p_oe),
    .peripheralBus_busy      (busy),
    .peripheralBus_address   (p_addr),
    .peripheralBus_byteSelect(p_sel),
    .peripheralBus_dataWrite (p_wd),
    .peripheralBus_dataRead  (rdat),
    .requestOutput           (req)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          busy;
    logic        req;
    logic [31:0] rdata;
    int          exp_ack;
    int          exp_we;
    int          exp_oe;
    logic [23:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle 0 is the select cycle; counts are in cycles relative to it.
  task automatic run_access(input vec_t v, input int budget,
                            output int ack_at, output int err_at,
                            output int we_n, output int oe_n,
                            output logic [23:0] a_seen, output logic [3:0] s_seen,
                            output logic [31:0] wd_seen, output logic [31:0] rd_seen);
    ack_at = -1; err_at = -1; we_n = 0; oe_n = 0;
    a_seen = '0; s_seen = '0; wd_seen = '0; rd_seen = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_in = v.we; sel = v.sel; adr = v.adr; wdat = v.wdata;
    req = v.req; rdat = v.rdata; busy = 1'b0;
    for (int c = 0; c <= budget; c++) begin
      @(negedge clk);
      if (p_we || p_oe) begin
        if (we_n + oe_n == 0) begin
          a_seen = p_addr; s_seen = p_sel; wd_seen = p_wd;
        end
        if (p_we) we_n++;
        if (p_oe) oe_n++;
      end
      if (ack) begin ack_at = c; rd_seen = rd_out; end
      if (err) begin err_at = c; rd_seen = rd_out; end
      busy = (p_we || p_oe) && (we_n + oe_n <= v.busy);
      if (ack || err) break;
    end
    cyc = 1'b0; stb = 1'b0; busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_at, err_at, we_n, oe_n, t1, t2, hits;
    logic [23:0] a_seen;
    logic [3:0]  s_seen;
    logic [31:0] wd_seen, rd_seen;
    vec_t v;

    vecs[0] = '{1'b1, 32'h3000_0104, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0,         2, 1, 0, 24'h000104, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 0, 1'b1, 32'h0000_00A5, 2, 0, 1, 24'h000010, 32'h0000_00A5};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'h1, 0, 1'b0, 32'h1234_5678, 2, 0, 1, 24'h000020, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 32'h3100_0000, 32'h0,         4'hF, 0, 1'b1, 32'h0000_0055, -1, 0, 0, 24'h0,     32'h0};
    vecs[4] = '{1'b1, 32'h3000_0200, 32'h1122_3344, 4'h3, 5, 1'b0, 32'h0,         7, 6, 0, 24'h000200, 32'h0};
    vecs[5] = '{1'b0, 32'h30AB_CDEC, 32'h0,         4'hC, 2, 1'b1, 32'hCAFE_0001, 4, 0, 3, 24'hABCDEC, 32'hCAFE_0001};
    vecs[6] = '{1'b1, 32'h30FF_FFFC, 32'h0BAD_F00D, 4'h8, 0, 1'b0, 32'h0,         2, 1, 0, 24'hFFFFFC, 32'h0};

    // Reset state
    #12;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_we", {31'b0, p_we}, 32'h0);
    chk("rst_oe", {31'b0, p_oe}, 32'h0);
    chk("rst_addr", {8'h0, p_addr}, 32'h0);
    chk("rst_sel", {28'h0, p_sel}, 32'h0);
    chk("rst_wd", p_wd, 32'h0);
    chk("rst_rd", rd_out, 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_access(v, 12, ack_at, err_at, we_n, oe_n, a_seen, s_seen, wd_seen, rd_seen);
      chk($sformatf("v%0d_ack_at", i), ack_at, v.exp_ack);
      chk($sformatf("v%0d_err", i), err_at, -1);
      chk($sformatf("v%0d_we_cycles", i), we_n, v.exp_we);
      chk($sformatf("v%0d_oe_cycles", i), oe_n, v.exp_oe);
      if (v.exp_we + v.exp_oe > 0) begin
        chk($sformatf("v%0d_addr", i), {8'h0, a_seen}, {8'h0, v.exp_addr});
        chk($sformatf("v%0d_bytesel", i), {28'h0, s_seen}, {28'h0, v.sel});
        chk($sformatf("v%0d_datawrite", i), wd_seen, v.wdata);
      end
      if (v.exp_ack >= 0) chk($sformatf("v%0d_rdata", i), rd_seen, v.exp_rd);
      @(negedge clk);
      chk($sformatf("v%0d_ack_one_cycle", i), {31'b0, ack}, 32'h0);
    end

    // Back-to-back: second select presented in the IDLE cycle right after the first ack
    run_access(vecs[0], 12, ack_at, err_at, we_n, oe_n, a_seen, s_seen, wd_seen, rd_seen);
    t1 = cycle_no;
    run_access(vecs[1], 12, ack_at, err_at, we_n, oe_n, a_seen, s_seen, wd_seen, rd_seen);
    t2 = cycle_no;
    chk("b2b_first_ack_seen", ack_at, 2);
    chk("b2b_ack_spacing", t2 - t1, 3);
    chk("b2b_rdata", rd_seen, 32'h0000_00A5);

    // wb_cyc_i dropped mid-access
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_in = 1'b0; adr = 32'h3000_0040; sel = 4'hF; req = 1'b1; busy = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("cycdrop_oe_before", {31'b0, p_oe}, 32'h1);
    @(negedge clk);
    chk("cycdrop_oe_held", {31'b0, p_oe}, 32'h1);
    cyc = 1'b0; stb = 1'b0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack || err || p_oe || p_we) hits++;
    end
    chk("cycdrop_quiet", hits, 0);
    busy = 1'b0;

    // Asynchronous reset mid-access
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we_in = 1'b1; adr = 32'h3000_0888; wdat = 32'hA5A5_5A5A; sel = 4'h6; busy = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rstmid_we_before", {31'b0, p_we}, 32'h1);
    rst = 1'b0; #1;
    chk("rstmid_we", {31'b0, p_we}, 32'h0);
    chk("rstmid_addr", {8'h0, p_addr}, 32'h0);
    chk("rstmid_wd", p_wd, 32'h0);
    chk("rstmid_sel", {28'h0, p_sel}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; busy = 1'b0; rst = 1'b1;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack || err || p_oe || p_we) hits++;
    end
    chk("rstmid_quiet", hits, 0);

    // Peripheral stuck busy
    v = vecs[1];
    v.busy = 100000;
`ifdef BRIDGE_TIMEOUT_EN
    run_access(v, 30, ack_at, err_at, we_n, oe_n, a_seen, s_seen, wd_seen, rd_seen);
    chk("to_err_at", err_at, 9);
    chk("to_no_ack", ack_at, -1);
    chk("to_oe_cycles", oe_n, 8);
    chk("to_rdata", rd_seen, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("to_err_one_cycle", {31'b0, err}, 32'h0);
`else
    run_access(v, 300, ack_at, err_at, we_n, oe_n, a_seen, s_seen, wd_seen, rd_seen);
    chk("hang_no_ack", ack_at, -1);
    chk("hang_no_err", err_at, -1);
    chk("hang_oe_cycles", oe_n, 300);
    @(negedge clk);
    chk("hang_released", {31'b0, p_oe}, 32'h0);
`endif

    // Bridge still usable afterwards
    run_access(vecs[5], 12, ack_at, err_at, we_n, oe_n, a_seen, s_seen, wd_seen, rd_seen);
    chk("final_ack_at", ack_at, 4);
    chk("final_rdata", rd_seen, 32'hCAFE_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
